// File: rtl/ccip_host_mem_responder.sv
// CCI-P host-memory responder: services c0 reads / c1 writes from a line-addressed
// memory and answers on ccip_rx with fixed latency, queueing and stall backpressure.

package ccip_if_pkg;
  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [15:0]  t_ccip_mdata;
  typedef logic [511:0] t_ccip_clData;

  typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;
  typedef enum logic [3:0] {eRSP_WRLINE = 4'h0, eRSP_WRFENCE = 4'h4} t_ccip_c1_rsp;

  typedef struct packed {
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c0_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;
endpackage

// One response channel: LAT-stage request pipeline feeding an in-order queue.
// An exiting entry bypasses the empty queue so minimum latency is LAT+1 cycles.
module ccip_rsp_chan #(
  parameter int LAT             = 8,
  parameter int PW              = 16,
  parameter int DW              = 16,
  parameter int Q_DEPTH         = 32,
  parameter int ALM_FULL_MARGIN = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [PW-1:0] in_pl,
  output logic [PW-1:0] exit_pl,
  input  logic [DW-1:0] exit_data,
  input  logic          stall,
  output logic          accept,
  output logic          issue,
  output logic          out_valid,
  output logic          alm_full,
  output logic [DW-1:0] out_data
);
  localparam int QW = $clog2(Q_DEPTH);
  localparam int CW = $clog2(Q_DEPTH + 1);
  localparam logic [CW-1:0] FULL   = CW'(Q_DEPTH);
  localparam logic [CW-1:0] THRESH = CW'(Q_DEPTH - ALM_FULL_MARGIN);

  logic [LAT-1:0] pv_r;
  logic [PW-1:0]  pd_r [LAT];
  logic [DW-1:0]  q_mem_r [Q_DEPTH];
  logic [QW-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]  q_cnt_r, occ_r, occ_next_s;
  logic           q_push_s, q_pop_s, q_nonempty_s;
  logic [DW-1:0]  head_s;

  assign exit_pl = pd_r[LAT-1];

  // Issue/accept decisions; a full channel still accepts when it issues the same cycle
  always_comb begin
    q_nonempty_s = (q_cnt_r != '0);
    issue        = !stall && (q_nonempty_s || pv_r[LAT-1]);
    accept       = in_valid && ((occ_r != FULL) || issue);
    q_pop_s      = issue && q_nonempty_s;
    q_push_s     = pv_r[LAT-1] && (stall || q_nonempty_s);
    head_s       = q_nonempty_s ? q_mem_r[rd_ptr_r] : exit_data;
    occ_next_s   = occ_r + CW'(accept) - CW'(issue);
  end

  // Control state, occupancy and registered response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv_r      <= '0;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      q_cnt_r   <= '0;
      occ_r     <= '0;
      alm_full  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      pv_r[0] <= accept;
      for (int i = 1; i < LAT; i++) pv_r[i] <= pv_r[i-1];
      if (q_push_s) wr_ptr_r <= wr_ptr_r + QW'(1);
      if (q_pop_s)  rd_ptr_r <= rd_ptr_r + QW'(1);
      q_cnt_r   <= q_cnt_r + CW'(q_push_s) - CW'(q_pop_s);
      occ_r     <= occ_next_s;
      alm_full  <= (occ_next_s >= THRESH);
      out_valid <= issue;
      if (issue) out_data <= head_s;
    end
  end

  // Pipeline payload and queue storage need no reset; validity is tracked above
  always_ff @(posedge clk) begin
    pd_r[0] <= in_pl;
    for (int i = 1; i < LAT; i++) pd_r[i] <= pd_r[i-1];
    if (q_push_s) q_mem_r[wr_ptr_r] <= exit_data;
  end
endmodule

module ccip_host_mem_responder
  import ccip_if_pkg::*;
#(
  parameter int MEM_LINES       = 1024,
  parameter int RD_LATENCY      = 8,
  parameter int WR_LATENCY      = 4,
  parameter int Q_DEPTH         = 32,
  parameter int ALM_FULL_MARGIN = 8,
  parameter int DSM_LINE        = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  t_if_ccip_c0_Tx               ccip_c0_tx,
  input  t_if_ccip_c1_Tx               ccip_c1_tx,
  output t_if_ccip_Rx                  ccip_rx,
  input  logic                         rsp_stall,
  input  logic                         load_en,
  input  logic [$clog2(MEM_LINES)-1:0] load_addr,
  input  logic [511:0]                 load_data,
  output logic                         done,
  output logic                         overflow_err,
  output logic [31:0]                  rd_count,
  output logic [31:0]                  wr_count
);
  localparam int AW = $clog2(MEM_LINES);

  logic [511:0]  mem_r [MEM_LINES];
  logic [AW-1:0] rd_line_s, wr_line_s;
  logic [AW+15:0] rd_exit_pl_s;
  logic [527:0]  rd_exit_data_s, rd_out_s;
  logic [15:0]   wr_exit_pl_s, wr_out_s;
  logic          rd_accept_s, rd_issue_s, rd_valid_s, rd_alm_s;
  logic          wr_accept_s, wr_issue_s, wr_valid_s, wr_alm_s;
  logic          unused_addr_s;

  assign rd_line_s      = ccip_c0_tx.hdr.address[AW-1:0];
  assign wr_line_s      = ccip_c1_tx.hdr.address[AW-1:0];
  assign unused_addr_s  = ^{ccip_c0_tx.hdr.address[41:AW], ccip_c1_tx.hdr.address[41:AW]};
  assign rd_exit_data_s = {mem_r[rd_exit_pl_s[AW+15:16]], rd_exit_pl_s[15:0]};

  ccip_rsp_chan #(
    .LAT(RD_LATENCY), .PW(AW + 16), .DW(528), .Q_DEPTH(Q_DEPTH), .ALM_FULL_MARGIN(ALM_FULL_MARGIN)
  ) u_rd (
    .clk(clk), .reset(reset), .in_valid(ccip_c0_tx.valid),
    .in_pl({rd_line_s, ccip_c0_tx.hdr.mdata}), .exit_pl(rd_exit_pl_s), .exit_data(rd_exit_data_s),
    .stall(rsp_stall), .accept(rd_accept_s), .issue(rd_issue_s), .out_valid(rd_valid_s),
    .alm_full(rd_alm_s), .out_data(rd_out_s)
  );

  ccip_rsp_chan #(
    .LAT(WR_LATENCY), .PW(16), .DW(16), .Q_DEPTH(Q_DEPTH), .ALM_FULL_MARGIN(ALM_FULL_MARGIN)
  ) u_wr (
    .clk(clk), .reset(reset), .in_valid(ccip_c1_tx.valid),
    .in_pl(ccip_c1_tx.hdr.mdata), .exit_pl(wr_exit_pl_s), .exit_data(wr_exit_pl_s),
    .stall(rsp_stall), .accept(wr_accept_s), .issue(wr_issue_s), .out_valid(wr_valid_s),
    .alm_full(wr_alm_s), .out_data(wr_out_s)
  );

  // Backdoor load first so a same-line c1 write in the same cycle overrides it
  always_ff @(posedge clk) begin
    if (load_en)     mem_r[load_addr] <= load_data;
    if (wr_accept_s) mem_r[wr_line_s] <= ccip_c1_tx.data;
  end

  // Sticky status flags and response counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done         <= 1'b0;
      overflow_err <= 1'b0;
      rd_count     <= 32'd0;
      wr_count     <= 32'd0;
    end else begin
      if (wr_accept_s && (wr_line_s == AW'(DSM_LINE)) && ccip_c1_tx.data[0]) done <= 1'b1;
      if ((ccip_c0_tx.valid && !rd_accept_s) || (ccip_c1_tx.valid && !wr_accept_s))
        overflow_err <= 1'b1;
      rd_count <= rd_count + 32'(rd_issue_s);
      wr_count <= wr_count + 32'(wr_issue_s);
    end
  end

  // Pack the channel registers into the rx bundle
  always_comb begin
    ccip_rx                    = '0;
    ccip_rx.c0TxAlmFull        = rd_alm_s;
    ccip_rx.c1TxAlmFull        = wr_alm_s;
    ccip_rx.c0.rspValid        = rd_valid_s;
    ccip_rx.c0.hdr.resp_type   = eRSP_RDLINE;
    ccip_rx.c0.hdr.mdata       = rd_out_s[15:0];
    ccip_rx.c0.data            = rd_out_s[527:16];
    ccip_rx.c1.rspValid        = wr_valid_s;
    ccip_rx.c1.hdr.resp_type   = eRSP_WRLINE;
    ccip_rx.c1.hdr.mdata       = wr_out_s;
  end
endmodule

// File: tb/tb_ccip_host_mem_responder.sv
// Directed bench for ccip_host_mem_responder with default parameters.
module tb_ccip_host_mem_responder;
  import ccip_if_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  t_if_ccip_c0_Tx c0_tx;
  t_if_ccip_c1_Tx c1_tx;
  t_if_ccip_Rx    rx;
  logic           rsp_stall, load_en, done, overflow_err;
  logic [9:0]     load_addr;
  logic [511:0]   load_data;
  logic [31:0]    rd_count, wr_count;
  int             n_cmp = 0;
  int             n_err = 0;
  int             idx;
  int             seen;
  logic [527:0]   exp_d;

  ccip_host_mem_responder dut (
    .clk(clk), .reset(reset), .ccip_c0_tx(c0_tx), .ccip_c1_tx(c1_tx), .ccip_rx(rx),
    .rsp_stall(rsp_stall), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .done(done), .overflow_err(overflow_err), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [527:0] got, input logic [527:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rd_req(input logic [41:0] addr, input logic [15:0] md);
    c0_tx.valid = 1'b1;
    c0_tx.hdr.address = addr;
    c0_tx.hdr.mdata = md;
  endtask

  task automatic wr_req(input logic [41:0] addr, input logic [15:0] md, input logic [511:0] d);
    c1_tx.valid = 1'b1;
    c1_tx.hdr.address = addr;
    c1_tx.hdr.mdata = md;
    c1_tx.data = d;
  endtask

  initial begin
    reset = 1'b1; c0_tx = '0; c1_tx = '0; rsp_stall = 1'b0;
    load_en = 1'b0; load_addr = 10'd0; load_data = 512'd0;
    tick(2);
    chk("rst_c0_almfull", 528'(rx.c0TxAlmFull), 528'(0));
    chk("rst_c1_almfull", 528'(rx.c1TxAlmFull), 528'(0));
    chk("rst_c0_valid", 528'(rx.c0.rspValid), 528'(0));
    chk("rst_c1_valid", 528'(rx.c1.rspValid), 528'(0));
    chk("rst_c0_data", 528'(rx.c0.data), 528'(0));
    chk("rst_done", 528'(done), 528'(0));
    chk("rst_ovf", 528'(overflow_err), 528'(0));
    chk("rst_counts", 528'({rd_count, wr_count}), 528'(0));
    reset = 1'b0;
    tick(1);

    // backdoor preload of lines 0..3
    for (int i = 0; i < 4; i++) begin
      load_en = 1'b1; load_addr = 10'(i); load_data = 512'(32'hA0 + i);
      tick(1);
    end
    load_en = 1'b0;
    tick(1);

    // two reads: line 3 md 5, line 1 md 6
    rd_req(42'd3, 16'd5); tick(1);
    rd_req(42'd1, 16'd6); tick(1);
    c0_tx.valid = 1'b0;
    tick(6);
    chk("rd_early", 528'(rx.c0.rspValid), 528'(0));
    tick(1);
    chk("rd0_valid", 528'(rx.c0.rspValid), 528'(1));
    chk("rd0_data", 528'(rx.c0.data), 528'(32'hA3));
    chk("rd0_mdata", 528'(rx.c0.hdr.mdata), 528'(5));
    chk("rd0_type", 528'(rx.c0.hdr.resp_type), 528'(eRSP_RDLINE));
    tick(1);
    chk("rd1_valid", 528'(rx.c0.rspValid), 528'(1));
    chk("rd1_data", 528'(rx.c0.data), 528'(32'hA1));
    chk("rd1_mdata", 528'(rx.c0.hdr.mdata), 528'(6));
    tick(1);
    chk("rd_after", 528'(rx.c0.rspValid), 528'(0));
    chk("rd_count2", 528'(rd_count), 528'(2));

    // write line 7 then read it back the next cycle
    wr_req(42'd7, 16'd9, 512'h55); tick(1);
    c1_tx.valid = 1'b0;
    rd_req(42'd7, 16'd7); tick(1);
    c0_tx.valid = 1'b0;
    tick(2);
    chk("wr_early", 528'(rx.c1.rspValid), 528'(0));
    tick(1);
    chk("wr_valid", 528'(rx.c1.rspValid), 528'(1));
    chk("wr_mdata", 528'(rx.c1.hdr.mdata), 528'(9));
    chk("wr_type", 528'(rx.c1.hdr.resp_type), 528'(eRSP_WRLINE));
    chk("wr_count1", 528'(wr_count), 528'(1));
    tick(5);
    chk("raw_valid", 528'(rx.c0.rspValid), 528'(1));
    chk("raw_data", 528'(rx.c0.data), 528'(32'h55));
    chk("raw_mdata", 528'(rx.c0.hdr.mdata), 528'(7));

    // address wrap: MEM_LINES+2 maps to line 2
    tick(2);
    rd_req(42'd1026, 16'd8); tick(1);
    c0_tx.valid = 1'b0;
    tick(8);
    chk("wrap_valid", 528'(rx.c0.rspValid), 528'(1));
    chk("wrap_data", 528'(rx.c0.data), 528'(32'hA2));
    chk("wrap_mdata", 528'(rx.c0.hdr.mdata), 528'(8));

    // DSM completion write
    tick(2);
    wr_req(42'd0, 16'd3, 512'h1); tick(1);
    c1_tx.valid = 1'b0;
    chk("done_set", 528'(done), 528'(1));
    tick(4);
    chk("dsm_wr_valid", 528'(rx.c1.rspValid), 528'(1));
    chk("dsm_wr_mdata", 528'(rx.c1.hdr.mdata), 528'(3));
    chk("wr_count2", 528'(wr_count), 528'(2));

    // stalled burst: almost-full at 24, 32 accepted, 33rd overflows
    tick(2);
    rsp_stall = 1'b1;
    for (int i = 0; i < 24; i++) begin
      rd_req(42'(i % 4), 16'(i)); tick(1);
      if (i == 22) chk("almfull_23", 528'(rx.c0TxAlmFull), 528'(0));
    end
    chk("almfull_24", 528'(rx.c0TxAlmFull), 528'(1));
    for (int i = 24; i < 32; i++) begin
      rd_req(42'(i % 4), 16'(i)); tick(1);
    end
    chk("ovf_32", 528'(overflow_err), 528'(0));
    rd_req(42'd0, 16'd32); tick(1);
    c0_tx.valid = 1'b0;
    chk("ovf_33", 528'(overflow_err), 528'(1));
    tick(10);
    chk("stall_hold", 528'(rx.c0.rspValid), 528'(0));
    chk("rd_count_stall", 528'(rd_count), 528'(4));
    rsp_stall = 1'b0;
    idx = 0;
    for (int c = 0; c < 60; c++) begin
      tick(1);
      if (rx.c0.rspValid) begin
        exp_d = (idx % 4 == 0) ? 528'(1) : 528'(32'hA0 + (idx % 4));
        chk("burst_mdata", 528'(rx.c0.hdr.mdata), 528'(idx));
        chk("burst_data", 528'(rx.c0.data), exp_d);
        idx++;
      end
    end
    chk("burst_total", 528'(idx), 528'(32));
    chk("rd_count36", 528'(rd_count), 528'(36));
    chk("almfull_drain", 528'(rx.c0TxAlmFull), 528'(0));

    // reset with 5 reads in flight
    for (int i = 0; i < 5; i++) begin
      rd_req(42'd1, 16'(20 + i)); tick(1);
    end
    c0_tx.valid = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_flags", 528'({rx.c0TxAlmFull, rx.c1TxAlmFull, done, overflow_err}), 528'(0));
    chk("mid_rst_counts", 528'({rd_count, wr_count}), 528'(0));
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (rx.c0.rspValid) seen++;
    end
    chk("no_stale_rsp", 528'(seen), 528'(0));
    rd_req(42'd2, 16'd11); tick(1);
    c0_tx.valid = 1'b0;
    tick(8);
    chk("mem_kept_valid", 528'(rx.c0.rspValid), 528'(1));
    chk("mem_kept_data", 528'(rx.c0.data), 528'(32'hA2));
    chk("mem_kept_mdata", 528'(rx.c0.hdr.mdata), 528'(11));

    // DSM write with bit0 clear does not raise done
    tick(2);
    wr_req(42'd0, 16'd12, 512'h0); tick(1);
    c1_tx.valid = 1'b0;
    chk("done_clear", 528'(done), 528'(0));
    tick(4);
    chk("dsm0_wr_valid", 528'(rx.c1.rspValid), 528'(1));
    chk("dsm0_wr_mdata", 528'(rx.c1.hdr.mdata), 528'(12));
    chk("wr_count_after_rst", 528'(wr_count), 528'(1));
    chk("done_final", 528'(done), 528'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ccip_host_mem_responder.md
Name: ccip_host_mem_responder

Overview:
- Synthesizable CCI-P host-memory responder: the far end of the read/write request channels our AFU requestors drive.
- Accepts c0 read requests and c1 write requests, services them from an internal line-addressed memory and returns responses on ccip_rx with configurable latency and backpressure.
- Used in simulation and loopback builds to close the loop around requestor blocks without a real host.
- Also detects the requestor's completion write to the DSM line.

Parameters:
MEM_LINES, 1024, depth of internal memory in 512-bit cache lines (power of 2)
RD_LATENCY, 8, cycles from read-request acceptance to earliest c0 response (>=2)
WR_LATENCY, 4, cycles from write acceptance to c1 response (>=1)
Q_DEPTH, 32, entries in each pending-response queue (read and write, power of 2)
ALM_FULL_MARGIN, 8, almost-full asserted when occupancy >= Q_DEPTH - ALM_FULL_MARGIN
DSM_LINE, 0, line index whose write with data bit0=1 raises done

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
ccip_c0_tx  input  t_if_ccip_c0_Tx  read requests (valid, hdr.address, hdr.mdata)
ccip_c1_tx  input  t_if_ccip_c1_Tx  write requests (valid, hdr.address, hdr.mdata, data)
ccip_rx  output  t_if_ccip_Rx  c0TxAlmFull, c1TxAlmFull, c0 read responses, c1 write responses
rsp_stall  input  1  bench/loopback backpressure; holds both response queues when high
load_en  input  1  backdoor preload strobe
load_addr  input  $clog2(MEM_LINES)  backdoor line index
load_data  input  512  backdoor line data
done  output  1  sticky; DSM completion write seen
overflow_err  output  1  sticky; request arrived while its queue was full
rd_count  output  32  read responses issued
wr_count  output  32  write responses issued

Behaviour:
- Interface: one clock `clk`; `reset` is asynchronous, active-high.
- Reset: all ccip_rx fields 0 (including c0TxAlmFull and c1TxAlmFull), done=0, overflow_err=0, rd_count=0, wr_count=0. Both queues and both latency pipelines are emptied. Memory contents are not cleared.
- Reset mid-operation: all in-flight requests are discarded and no responses are emitted for them.
- Address mapping: line index = hdr.address[$clog2(MEM_LINES)-1:0]. Upper bits are ignored, so addresses wrap modulo MEM_LINES.
- Read accept: when ccip_c0_tx.valid is high, the request enters a RD_LATENCY-stage shift pipeline carrying mdata and line index.
- Read data: memory is read at pipeline exit, so a read sees every write accepted in an earlier cycle.
- Read response queue: at pipeline exit the entry {data, mdata} is pushed into the read response queue.
- Read response: when the queue is non-empty and rsp_stall=0, the queue is popped and drives, for one cycle:
  - c0.rspValid=1
  - c0.hdr.resp_type=eRSP_RDLINE
  - c0.hdr.mdata = request mdata
  - c0.data = line data
  - At most one read response per cycle; responses are in request order.
- Minimum read latency: RD_LATENCY+1 cycles from the request cycle to rspValid.
- Write accept: when ccip_c1_tx.valid is high, data is written to memory at the next clock edge. {mdata} then enters a WR_LATENCY pipeline, then the write response queue.
- Write response: on pop, for one cycle:
  - c1.rspValid=1
  - c1.hdr.resp_type=eRSP_WRLINE
  - c1.hdr.mdata echoed
  - In order; one per cycle.
- Channel independence: c0 and c1 responses may be issued in the same cycle.
- Backdoor load: load_en writes load_data to load_addr. If it collides with a c1 write to the same line in the same cycle, the c1 write wins.
- Occupancy: per channel, occupancy = pipeline entries + queue entries. cXTxAlmFull is registered high when occupancy >= Q_DEPTH - ALM_FULL_MARGIN, and low otherwise.
- Overflow: a request arriving while occupancy == Q_DEPTH is dropped, overflow_err is set (sticky until reset) and the corresponding count is not incremented.
- Simultaneous push and pop in the same cycle leaves occupancy unchanged and is legal when full.
- done: set the cycle after an accepted c1 write to DSM_LINE with data[0]=1. Sticky. The write is still stored and still acknowledged.
- Counters: rd_count and wr_count increment on each issued response. They wrap at 2^32.

Test Plan:
- Preload lines 0..3 with 0xA0..0xA3 via the backdoor. Issue reads to lines 3,1 with mdata 5,6, RD_LATENCY=8 -> responses at cycles +9,+10 with data 0xA3, 0xA1, mdata 5, 6, resp_type eRSP_RDLINE.
- Write 0x55 to line 7, then read line 7 the next cycle -> read returns 0x55. Write response arrives at +5 with mdata echoed; wr_count=1.
- Hold rsp_stall=1 and issue 24 back-to-back reads (defaults) -> c0TxAlmFull rises once occupancy reaches 24. 8 more reads are accepted, the 33rd sets overflow_err. Release the stall -> exactly 32 in-order responses.
- Read address MEM_LINES+2 -> returns the contents of line 2 (wrap).
- Write data 0x1 to DSM_LINE -> done=1 the next cycle and a write response is still issued. Write data 0x0 to DSM_LINE after reset -> done stays 0.
- Assert reset with 5 reads in flight -> no c0 responses afterwards, almost-full flags and counters at 0. Preloaded memory data is still readable.
